// File: rtl/fetch_mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_mem_arbiter_pkg : shared ids, defaults and order-queue entry type     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package fetch_mem_arbiter_pkg;

  localparam logic REQ_ID_INST      = 1'b0;
  localparam logic REQ_ID_DATA      = 1'b1;
  localparam int   DEF_OUTSTANDING  = 4;
  localparam int   DEF_STARVE_LIMIT = 3;

  typedef struct packed {
    logic id;
    logic drop;
  } order_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_mem_arbiter_req_order_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_mem_arbiter_req_order_queue : circular {id,drop} tracker of requests  |
// | in flight, with a one-shot "drop every instruction entry" mark. Rev 1.0     |
// +----------------------------------------------------------------------------+
module fetch_mem_arbiter_req_order_queue
  import fetch_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_OUTSTANDING
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         push_id,
  input  logic         pop,
  input  logic         flush_inst,
  output logic         empty,
  output logic         full,
  output order_entry_t head
);

  localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  order_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  assign empty = (r_count == '0);
  assign full  = (r_count == C_DEPTH);
  assign head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      // Stale slots may get marked too; they are rewritten on push.
      if (flush_inst) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (r_mem[k].id == REQ_ID_INST) r_mem[k].drop <= 1'b1;
        end
      end
      if (push) begin
        r_mem[r_wr_ptr] <= '{id: push_id, drop: 1'b0};
        r_wr_ptr        <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (pop) r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_mem_arbiter : data-priority arbiter of fetch and data ports onto one  |
// | in-order memory port, with fetch anti-starvation and flush drop. Rev 1.0    |
// +----------------------------------------------------------------------------+
module fetch_mem_arbiter
  import fetch_mem_arbiter_pkg::*;
#(
  parameter int OUTSTANDING  = DEF_OUTSTANDING,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        i_addr_valid,
  output logic        i_addr_ready,
  input  logic [31:0] i_addr,
  output logic        i_line_valid,
  input  logic        i_line_ready,
  output logic [31:0] i_line,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_wr,
  input  logic [3:0]  d_req_wstrb,
  input  logic [31:0] d_req_wdata,
  output logic        d_resp_valid,
  input  logic        d_resp_ready,
  output logic [31:0] d_resp_rdata,
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic [31:0] m_req_addr,
  output logic        m_req_wr,
  output logic [3:0]  m_req_wstrb,
  output logic [31:0] m_req_wdata,
  input  logic        m_resp_valid,
  output logic        m_resp_ready,
  input  logic [31:0] m_resp_rdata
);

  localparam int                  STARVE_W     = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] r_starve_cnt;
  logic                w_full;
  logic                w_empty;
  logic                w_grant_fetch;
  logic                w_fetch_hs;
  logic                w_data_hs;
  logic                w_req_hs;
  logic                w_resp_hs;
  logic                w_head_inst;
  logic                w_head_drop;
  order_entry_t        w_head;

  // A fetch presented during flush is treated as absent so data can still go.
  assign w_grant_fetch = i_addr_valid & ~flush &
                         (~d_req_valid | (r_starve_cnt == C_STARVE_MAX));

  assign m_req_valid  = rst & ~w_full & (w_grant_fetch | d_req_valid);
  assign i_addr_ready = rst & ~w_full & m_req_ready & w_grant_fetch;
  assign d_req_ready  = rst & ~w_full & m_req_ready & ~w_grant_fetch;

  assign m_req_addr  = w_grant_fetch ? i_addr : d_req_addr;
  assign m_req_wr    = w_grant_fetch ? 1'b0   : d_req_wr;
  assign m_req_wstrb = w_grant_fetch ? 4'h0   : d_req_wstrb;
  assign m_req_wdata = w_grant_fetch ? 32'h0  : d_req_wdata;

  assign w_fetch_hs = i_addr_valid & i_addr_ready;
  assign w_data_hs  = d_req_valid & d_req_ready;
  assign w_req_hs   = m_req_valid & m_req_ready;

  assign w_head_inst  = (w_head.id == REQ_ID_INST);
  assign w_head_drop  = w_head_inst & (w_head.drop | flush);
  assign i_line_valid = rst & ~w_empty & w_head_inst & ~w_head_drop & m_resp_valid;
  assign d_resp_valid = rst & ~w_empty & ~w_head_inst & m_resp_valid;
  assign i_line       = m_resp_rdata;
  assign d_resp_rdata = m_resp_rdata;

  always_comb begin
    m_resp_ready = 1'b0;
    if (rst && !w_empty) begin
      if (!w_head_inst)     m_resp_ready = d_resp_ready;
      else if (w_head_drop) m_resp_ready = 1'b1;
      else                  m_resp_ready = i_line_ready;
    end
  end

  assign w_resp_hs = m_resp_valid & m_resp_ready;

  fetch_mem_arbiter_req_order_queue #(
    .DEPTH (OUTSTANDING)
  ) u_req_order_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (w_req_hs),
    .push_id    (w_grant_fetch ? REQ_ID_INST : REQ_ID_DATA),
    .pop        (w_resp_hs),
    .flush_inst (flush),
    .empty      (w_empty),
    .full       (w_full),
    .head       (w_head)
  );

  always_ff @(posedge clk) begin
    if (!rst || !i_addr_valid || w_fetch_hs) begin
      r_starve_cnt <= '0;
    end else if (w_data_hs && (r_starve_cnt != C_STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_mem_arbiter : directed scenarios plus random traffic against a     |
// | queue-based reference model of the arbiter. Rev 1.0                        |
// +----------------------------------------------------------------------------+
module tb_fetch_mem_arbiter;

  localparam int OUTSTANDING  = 4;
  localparam int STARVE_LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        i_addr_valid, i_addr_ready, i_line_valid, i_line_ready;
  logic [31:0] i_addr, i_line;
  logic        d_req_valid, d_req_ready, d_req_wr, d_resp_valid, d_resp_ready;
  logic [31:0] d_req_addr, d_req_wdata, d_resp_rdata;
  logic [3:0]  d_req_wstrb;
  logic        m_req_valid, m_req_ready, m_req_wr, m_resp_valid, m_resp_ready;
  logic [31:0] m_req_addr, m_req_wdata, m_resp_rdata;
  logic [3:0]  m_req_wstrb;

  fetch_mem_arbiter #(
    .OUTSTANDING  (OUTSTANDING),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .i_addr_valid (i_addr_valid),
    .i_addr_ready (i_addr_ready),
    .i_addr       (i_addr),
    .i_line_valid (i_line_valid),
    .i_line_ready (i_line_ready),
    .i_line       (i_line),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_req_addr   (d_req_addr),
    .d_req_wr     (d_req_wr),
    .d_req_wstrb  (d_req_wstrb),
    .d_req_wdata  (d_req_wdata),
    .d_resp_valid (d_resp_valid),
    .d_resp_ready (d_resp_ready),
    .d_resp_rdata (d_resp_rdata),
    .m_req_valid  (m_req_valid),
    .m_req_ready  (m_req_ready),
    .m_req_addr   (m_req_addr),
    .m_req_wr     (m_req_wr),
    .m_req_wstrb  (m_req_wstrb),
    .m_req_wdata  (m_req_wdata),
    .m_resp_valid (m_resp_valid),
    .m_resp_ready (m_resp_ready),
    .m_resp_rdata (m_resp_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          inst;
    bit          drop;
    logic [31:0] addr;
  } pend_t;

  pend_t pend[$];
  int    starve   = 0;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    mem_mode = 0;  // 0 silent, 1 answer when owed, 2 random, 3 always valid
  bit    exp_grant [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pend[] is the list of memory transactions not yet answered.
  always @(negedge clk) begin : model
    bit   full, fetch_go, head_inst, head_drop;
    logic e_mreq_valid, e_iready, e_dready, e_ilv, e_drv, e_mrr;
    full = (pend.size() >= OUTSTANDING);
    fetch_go = 1'b0;
    {e_mreq_valid, e_iready, e_dready, e_ilv, e_drv, e_mrr} = '0;
    if (rst === 1'b1) begin
      fetch_go     = i_addr_valid && !flush && (!d_req_valid || starve >= STARVE_LIMIT);
      e_mreq_valid = !full && (fetch_go || d_req_valid);
      e_iready     = !full && m_req_ready && fetch_go;
      e_dready     = !full && m_req_ready && !fetch_go;
      if (pend.size() > 0) begin
        head_inst = pend[0].inst;
        head_drop = head_inst && (pend[0].drop || flush);
        e_ilv     = m_resp_valid && head_inst && !head_drop;
        e_drv     = m_resp_valid && !head_inst;
        e_mrr     = head_inst ? (head_drop ? 1'b1 : i_line_ready) : d_resp_ready;
      end
    end
    check("m_req_valid", m_req_valid, e_mreq_valid);
    check("i_addr_ready", i_addr_ready, e_iready);
    check("d_req_ready", d_req_ready, e_dready);
    check("i_line_valid", i_line_valid, e_ilv);
    check("d_resp_valid", d_resp_valid, e_drv);
    check("m_resp_ready", m_resp_ready, e_mrr);
    if (e_mreq_valid) begin
      check("m_req_addr", m_req_addr, fetch_go ? i_addr : d_req_addr);
      check("m_req_wr", m_req_wr, fetch_go ? 1'b0 : d_req_wr);
      check("m_req_wstrb", m_req_wstrb, fetch_go ? 4'h0 : d_req_wstrb);
      check("m_req_wdata", m_req_wdata, fetch_go ? 32'h0 : d_req_wdata);
    end
    if (e_ilv) check("i_line", i_line, mem_f(pend[0].addr));
    if (e_drv) check("d_resp_rdata", d_resp_rdata, mem_f(pend[0].addr));

    if (rst !== 1'b1) begin
      pend.delete();
      starve = 0;
    end else begin
      if (flush) begin
        for (int k = 0; k < pend.size(); k++) if (pend[k].inst) pend[k].drop = 1'b1;
      end
      if (e_mrr && m_resp_valid) void'(pend.pop_front());
      if (e_iready && i_addr_valid)     pend.push_back(pend_t'{1'b1, 1'b0, i_addr});
      else if (e_dready && d_req_valid) pend.push_back(pend_t'{1'b0, 1'b0, d_req_addr});
      if (!i_addr_valid || (e_iready && i_addr_valid)) starve = 0;
      else if (e_dready && d_req_valid && starve < STARVE_LIMIT) starve++;
    end
  end

  // Advance one cycle; the memory side answers in order from the model's list.
  task automatic step();
    @(posedge clk);
    #1;
    case (mem_mode)
      0:       m_resp_valid = 1'b0;
      1:       m_resp_valid = (pend.size() > 0);
      2:       m_resp_valid = ($urandom_range(0, 99) < 45);
      default: m_resp_valid = 1'b1;
    endcase
    m_resp_rdata = (pend.size() > 0) ? mem_f(pend[0].addr) : $urandom;
  endtask

  task automatic idle();
    flush = 0; i_addr_valid = 0; i_addr = '0; i_line_ready = 0;
    d_req_valid = 0; d_req_addr = '0; d_req_wr = 0; d_req_wstrb = '0; d_req_wdata = '0;
    d_resp_ready = 0; m_req_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    mem_mode = 0;
    rst = 0;
    step();
    rst = 1;
  endtask

  initial begin
    rst = 0; m_resp_valid = 0; m_resp_rdata = '0;
    idle();

    // Both requesters busy: three data grants, then one fetch.
    do_reset();
    mem_mode = 1; i_line_ready = 1; d_resp_ready = 1; m_req_ready = 1;
    i_addr_valid = 1; i_addr = 32'h0000_1000; d_req_valid = 1; d_req_addr = 32'h0000_2000;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("grant_fetch_%0d", k), i_addr_ready, exp_grant[k]);
      check($sformatf("grant_data_%0d", k), d_req_ready, !exp_grant[k]);
      step();
    end

    // Four fetches fill the tracker; the fifth waits for a pop plus one cycle.
    do_reset();
    m_req_ready = 1; i_addr_valid = 1; i_line_ready = 1;
    for (int k = 0; k < 4; k++) begin
      i_addr = 32'h0000_0100 + 32'(k * 4);
      #1 check("fill_ready", i_addr_ready, 1'b1);
      step();
    end
    #1 check("full_block_ready", i_addr_ready, 1'b0);
    check("full_block_mreq", m_req_valid, 1'b0);
    mem_mode = 1;
    step();
    #1 check("pop_line_valid", i_line_valid, 1'b1);
    check("pop_line_data", i_line, mem_f(32'h0000_0100));
    check("pop_not_credited", i_addr_ready, 1'b0);
    mem_mode = 0;
    step();
    #1 check("after_pop_ready", i_addr_ready, 1'b1);

    // Fetch A, data B, fetch C, then flush: A and C absorbed, B delivered.
    do_reset();
    m_req_ready = 1;
    i_addr_valid = 1; i_addr = 32'hA000_0000;
    step();
    i_addr_valid = 0; d_req_valid = 1; d_req_addr = 32'hB000_0040;
    step();
    d_req_valid = 0; i_addr_valid = 1; i_addr = 32'hC000_0080;
    step();
    flush = 1;
    #1 check("flush_fetch_ready", i_addr_ready, 1'b0);
    check("flush_mreq_valid", m_req_valid, 1'b0);
    mem_mode = 1;
    step();
    flush = 0; i_addr_valid = 0; i_line_ready = 0; d_resp_ready = 1;
    #1 check("drop_a_line_valid", i_line_valid, 1'b0);
    check("drop_a_mresp_ready", m_resp_ready, 1'b1);
    step();
    #1 check("b_resp_valid", d_resp_valid, 1'b1);
    check("b_resp_data", d_resp_rdata, mem_f(32'hB000_0040));
    step();
    #1 check("drop_c_line_valid", i_line_valid, 1'b0);
    check("drop_c_mresp_ready", m_resp_ready, 1'b1);
    mem_mode = 3;
    step();
    #1 check("unsolicited_stall", m_resp_ready, 1'b0);

    // Full-word write returns exactly one data response.
    do_reset();
    m_req_ready = 1; d_req_valid = 1; d_req_wr = 1; d_req_wstrb = 4'hF;
    d_req_addr = 32'h8000_0010; d_req_wdata = 32'hDEAD_BEEF;
    #1 check("wr_mreq_wr", m_req_wr, 1'b1);
    check("wr_mreq_addr", m_req_addr, 32'h8000_0010);
    check("wr_mreq_wstrb", m_req_wstrb, 4'hF);
    mem_mode = 1;
    step();
    d_req_valid = 0; d_resp_ready = 1; i_line_ready = 1;
    #1 check("wr_resp_valid", d_resp_valid, 1'b1);
    check("wr_no_line", i_line_valid, 1'b0);
    step();
    #1 check("wr_single_resp", d_resp_valid, 1'b0);

    // Reset with three outstanding fetches clears all tracking.
    do_reset();
    mem_mode = 3; m_req_ready = 1; i_addr_valid = 1; i_addr = 32'h0000_4000;
    repeat (3) step();
    rst = 0; d_req_valid = 1;
    #1 check("rst_i_addr_ready", i_addr_ready, 1'b0);
    check("rst_d_req_ready", d_req_ready, 1'b0);
    check("rst_m_req_valid", m_req_valid, 1'b0);
    check("rst_m_resp_ready", m_resp_ready, 1'b0);
    step();
    rst = 1; d_req_valid = 0;
    #1 check("post_rst_fetch_grant", i_addr_ready, 1'b1);
    check("post_rst_empty", m_resp_ready, 1'b0);

    // Random traffic with occasional flush and reset.
    mem_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 199) != 0);
      flush        = ($urandom_range(0, 9) == 0);
      i_addr_valid = ($urandom_range(0, 3) != 0);
      i_addr       = $urandom;
      d_req_valid  = ($urandom_range(0, 3) != 0);
      d_req_addr   = $urandom;
      d_req_wr     = 1'($urandom_range(0, 1));
      d_req_wstrb  = 4'($urandom_range(0, 15));
      d_req_wdata  = $urandom;
      m_req_ready  = ($urandom_range(0, 3) != 0);
      i_line_ready = ($urandom_range(0, 3) != 0);
      d_resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    idle();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
